// File: rtl/wt_mem_responder.sv
// wt_mem_responder
//   Behavioural memory slave with a fixed-latency, in-order response path.
//   Requests are accepted while fewer than MaxOutstanding transactions are in
//   flight and the request TID is not already in use. Each accepted request
//   reads or writes a word-addressed backing array at the accept edge. Its
//   response record then travels through a Latency-deep delay pipeline into an
//   in-order response FIFO.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   req_valid_i/ready_o    request handshake
//   req_we_i               1 = store, 0 = load
//   req_addr_i             byte address (low offset bits ignored)
//   req_wdata_i, req_be_i  store data and per-byte enables
//   req_tid_i              transaction ID
//   rsp_valid_o/ready_i    response handshake
//   rsp_we_o, rsp_tid_o    echoes of the request
//   rsp_rdata_o            load data (0 for stores and errors)
//   rsp_err_o              address was outside the backed range
module wt_mem_responder #(
    parameter int          MemTidWidth    = 2,
    parameter int          DataWidth      = 64,
    parameter int          AddrWidth      = 64,
    parameter logic [63:0] BaseAddr       = 64'h8000_0000,
    parameter int          DepthWords     = 256,
    parameter int          Latency        = 2,
    parameter int          MaxOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [DataWidth-1:0]   req_wdata_i,
    input  logic [DataWidth/8-1:0] req_be_i,
    input  logic [MemTidWidth-1:0] req_tid_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   rsp_we_o,
    output logic [MemTidWidth-1:0] rsp_tid_o,
    output logic [DataWidth-1:0]   rsp_rdata_o,
    output logic                   rsp_err_o
);

    localparam int NB    = DataWidth / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DepthWords);
    localparam int PTR_W = $clog2(MaxOutstanding);
    localparam int CNT_W = PTR_W + 1;
    localparam int NTID  = 1 << MemTidWidth;

    localparam logic [AddrWidth-1:0] BASE  = AddrWidth'(BaseAddr);
    // One extra bit so the end of the window cannot wrap for a high base.
    localparam logic [AddrWidth:0]   LIMIT = {1'b0, BASE} + (AddrWidth+1)'(DepthWords * NB);
    localparam logic [CNT_W-1:0]     MAX_OUT = CNT_W'(MaxOutstanding);

    typedef struct packed {
        logic                   we;
        logic [MemTidWidth-1:0] tid;
        logic [DataWidth-1:0]   rdata;
        logic                   err;
    } rsp_t;

    logic [DataWidth-1:0] mem [DepthWords];

    logic [CNT_W-1:0]     out_cnt;
    logic [NTID-1:0]      busy;
    logic [Latency-1:0]   vld_pipe;
    rsp_t                 pipe_q [Latency];
    rsp_t                 fifo_q [MaxOutstanding];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     fifo_cnt;

    logic                 req_fire, rsp_fire, in_range, push;
    logic [AddrWidth-1:0] offset;
    logic [IDX_W-1:0]     idx;
    rsp_t                 in_ent, head;

    // Address decode
    assign offset   = req_addr_i - BASE;
    assign idx      = IDX_W'(offset >> OFF_W);
    assign in_range = ({1'b0, req_addr_i} >= {1'b0, BASE}) && ({1'b0, req_addr_i} < LIMIT);

    // Handshakes
    assign req_ready_o = !rst_i && (out_cnt < MAX_OUT) && !busy[req_tid_i];
    assign req_fire    = req_valid_i && req_ready_o;
    assign rsp_valid_o = (fifo_cnt != '0);
    assign rsp_fire    = rsp_valid_o && rsp_ready_i;
    assign push        = vld_pipe[Latency-1];

    // Head of FIFO drives the response; gated so idle outputs read as zero.
    assign head        = fifo_q[rd_ptr];
    assign rsp_we_o    = rsp_valid_o & head.we;
    assign rsp_tid_o   = rsp_valid_o ? head.tid   : '0;
    assign rsp_rdata_o = rsp_valid_o ? head.rdata : '0;
    assign rsp_err_o   = rsp_valid_o & head.err;

    // Response record built at accept time. The load reads the array before
    // this edge's write, so it sees every earlier store and no later one.
    always_comb begin
        in_ent       = '0;
        in_ent.we    = req_we_i;
        in_ent.tid   = req_tid_i;
        in_ent.err   = !in_range;
        in_ent.rdata = (!req_we_i && in_range) ? mem[idx] : '0;
    end

    // Backing store: never reset, so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (req_fire && req_we_i && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be_i[b]) mem[idx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
            end
        end
    end

    // In-flight count and busy-TID set. The set is applied after the clear,
    // so a same-TID pop and accept in one cycle leaves the bit set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_cnt <= '0;
            busy    <= '0;
        end else begin
            case ({req_fire, rsp_fire})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: ;
            endcase
            if (rsp_fire) busy[rsp_tid_o] <= 1'b0;
            if (req_fire) busy[req_tid_i] <= 1'b1;
        end
    end

    // Delay pipeline: only the valid bits need reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= req_fire;
            for (int i = 1; i < Latency; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        pipe_q[0] <= in_ent;
        for (int i = 1; i < Latency; i++) pipe_q[i] <= pipe_q[i-1];
        if (push) fifo_q[wr_ptr] <= pipe_q[Latency-1];
    end

    // Response FIFO control. The in-flight cap guarantees it never overflows,
    // and a push and a pop on a full FIFO both proceed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (rsp_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({push, rsp_fire})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wt_mem_responder.sv
// Self-checking bench for wt_mem_responder: a table of single transactions
// plus hand-written sequences for latency, backpressure, TID reuse and reset.
// Expected responses are queued when a request is seen accepted and compared
// by a monitor when the DUT hands a response over.
module tb_wt_mem_responder;

    localparam int TW = 2;
    localparam int DW = 64;
    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [7:0]    req_be = '0;
    logic [TW-1:0] req_tid = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_we;
    logic [TW-1:0] rsp_tid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    wt_mem_responder dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .req_tid_i   (req_tid),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_we_o    (rsp_we),
        .rsp_tid_o   (rsp_tid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [TW-1:0] tid;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [7:0]    be;
        logic [TW-1:0] tid;
        logic          err;
        logic [DW-1:0] rdata;
    } vec_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a response seen valid+ready at the falling edge transfers on
    // the next rising edge. Also checks that a stalled response holds.
    initial begin : monitor
        exp_t e;
        exp_t snap;
        logic hold_v;
        hold_v = 1'b0;
        snap   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("hold_valid", DW'(rsp_valid), 64'd1);
                    chk("hold_rdata", rsp_rdata, snap.rdata);
                    chk("hold_tid_we_err", DW'({rsp_we, rsp_tid, rsp_err}),
                        DW'({snap.we, snap.tid, snap.err}));
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_rsp: got tid %0d with no response expected", rsp_tid);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_we", DW'(rsp_we), DW'(e.we));
                        chk("rsp_tid", DW'(rsp_tid), DW'(e.tid));
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", DW'(rsp_err), DW'(e.err));
                    end
                end
                hold_v = rsp_valid && !rsp_ready;
                snap   = '{we: rsp_we, tid: rsp_tid, rdata: rsp_rdata, err: rsp_err};
            end
        end
    end

    task automatic drive_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input logic [7:0] be, input logic [TW-1:0] tid);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_tid   = tid;
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [7:0] be, input logic [TW-1:0] tid,
                         input logic push, input exp_t e);
        int n;
        drive_req(we, addr, wdata, be, tid);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: tid %0d not accepted, ready stayed 0 expected 1", tid);
        end else if (push) begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d responses pending, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [DW-1:0] W0A = 64'h1122_3344_5566_7788;
    localparam logic [DW-1:0] W0B = 64'h1122_3344_BBBB_BBBB;
    localparam logic [DW-1:0] W0C = 64'hFFEE_3344_BBBB_9988;
    localparam logic [DW-1:0] WTOP = 64'hDEAD_BEEF_0123_4567;
    localparam logic [DW-1:0] W2 = 64'h5555_6666_7777_8888;

    vec_t vecs[14];

    initial begin : main
        exp_t e;
        vecs[0]  = '{1'b0, 64'h8000_0000, '0, 8'h00, 2'd1, 1'b0, W0A};
        vecs[1]  = '{1'b1, 64'h8000_0000, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 2'd2, 1'b0, '0};
        vecs[2]  = '{1'b0, 64'h8000_0000, '0, 8'h00, 2'd3, 1'b0, W0B};
        vecs[3]  = '{1'b0, 64'h7FFF_FFF8, '0, 8'h00, 2'd0, 1'b1, '0};
        vecs[4]  = '{1'b0, 64'h8000_0800, '0, 8'h00, 2'd1, 1'b1, '0};
        vecs[5]  = '{1'b0, 64'h8000_0000, '0, 8'h00, 2'd2, 1'b0, W0B};
        vecs[6]  = '{1'b1, 64'h8000_07F8, WTOP, 8'hFF, 2'd3, 1'b0, '0};
        vecs[7]  = '{1'b0, 64'h8000_07FF, '0, 8'h00, 2'd0, 1'b0, WTOP};
        vecs[8]  = '{1'b1, 64'h8000_0800, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'd1, 1'b1, '0};
        vecs[9]  = '{1'b0, 64'h8000_07F8, '0, 8'h00, 2'd2, 1'b0, WTOP};
        vecs[10] = '{1'b1, 64'h7FFF_FFF8, 64'h1234_5678_9ABC_DEF0, 8'hFF, 2'd3, 1'b1, '0};
        vecs[11] = '{1'b0, 64'h8000_0004, '0, 8'h00, 2'd0, 1'b0, W0B};
        vecs[12] = '{1'b1, 64'h8000_0000, 64'hFFEE_DDCC_BBAA_9988, 8'hC3, 2'd1, 1'b0, '0};
        vecs[13] = '{1'b0, 64'h8000_0000, '0, 8'h00, 2'd2, 1'b0, W0C};

        // Reset state, with a request offered to show it is refused.
        drive_req(1'b0, 64'h8000_0000, '0, 8'h00, 2'd0);
        repeat (2) @(negedge clk);
        chk("rst_req_ready", DW'(req_ready), 64'd0);
        chk("rst_rsp_valid", DW'(rsp_valid), 64'd0);
        chk("rst_rsp_we", DW'(rsp_we), 64'd0);
        chk("rst_rsp_tid", DW'(rsp_tid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_err", DW'(rsp_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full store, ready straight after reset, response two edges later.
        drive_req(1'b1, 64'h8000_0000, W0A, 8'hFF, 2'd0);
        @(negedge clk);
        chk("ready_after_rst", DW'(req_ready), 64'd1);
        sb.push_back('{we: 1'b1, tid: 2'd0, rdata: '0, err: 1'b0});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("lat_edge0", DW'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge1", DW'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge2", DW'(rsp_valid), 64'd1);

        // Table: issued back-to-back, each response checked in order.
        for (int i = 0; i < 14; i++) begin
            e = '{we: vecs[i].we, tid: vecs[i].tid, rdata: vecs[i].rdata, err: vecs[i].err};
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].tid, 1'b1, e);
        end
        drain();

        // Backpressure: four in flight, fifth refused until the first pop.
        rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            drive_req(1'b0, 64'h8000_0000, '0, 8'h00, TW'(t));
            @(negedge clk);
            chk("bp_accept", DW'(req_ready), 64'd1);
            sb.push_back('{we: 1'b0, tid: TW'(t), rdata: W0C, err: 1'b0});
            @(posedge clk);
            #1;
        end
        drive_req(1'b0, 64'h8000_07F8, '0, 8'h00, 2'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_full_stall", DW'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_stall_before_pop", DW'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_ready_after_pop", DW'(req_ready), 64'd1);
        sb.push_back('{we: 1'b0, tid: 2'd0, rdata: WTOP, err: 1'b0});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drain();

        // TID reuse: second tid 2 waits for the first tid 2 response.
        issue(1'b0, 64'h8000_07F8, '0, 8'h00, 2'd2, 1'b1, '{we: 1'b0, tid: 2'd2, rdata: WTOP, err: 1'b0});
        drive_req(1'b0, 64'h8000_0000, '0, 8'h00, 2'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("tid_busy_stall", DW'(req_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("tid_free_after_pop", DW'(req_ready), 64'd1);
        sb.push_back('{we: 1'b0, tid: 2'd2, rdata: W0C, err: 1'b0});
        @(posedge clk);
        #1;
        drive_req(1'b0, 64'h8000_07F8, '0, 8'h00, 2'd2);
        @(negedge clk);
        chk("tid_rebusy_stall", DW'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        issue(1'b0, 64'h8000_07F8, '0, 8'h00, 2'd2, 1'b1, '{we: 1'b0, tid: 2'd2, rdata: WTOP, err: 1'b0});
        drain();

        // Reset with three in flight: all discarded, the store survives.
        rsp_ready = 1'b0;
        issue(1'b1, 64'h8000_0010, W2, 8'hFF, 2'd0, 1'b0, '0);
        issue(1'b0, 64'h8000_0010, '0, 8'h00, 2'd1, 1'b0, '0);
        issue(1'b0, 64'h8000_0000, '0, 8'h00, 2'd2, 1'b0, '0);
        rst = 1'b1;
        drive_req(1'b0, 64'h8000_0000, '0, 8'h00, 2'd3);
        @(negedge clk);
        chk("mid_rst_req_ready", DW'(req_ready), 64'd0);
        chk("mid_rst_rsp_valid", DW'(rsp_valid), 64'd0);
        chk("mid_rst_rsp_fields", DW'({rsp_we, rsp_tid, rsp_err}), 64'd0);
        chk("mid_rst_rsp_rdata", rsp_rdata, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", DW'(rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        // Count was cleared: four fresh requests fit without any pop.
        rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            drive_req(1'b0, 64'h8000_0010, '0, 8'h00, TW'(t));
            @(negedge clk);
            chk("post_rst_accept", DW'(req_ready), 64'd1);
            sb.push_back('{we: 1'b0, tid: TW'(t), rdata: W2, err: 1'b0});
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        chk("sb_empty", DW'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
